// File: rtl/fir_mavg_stream.sv
// rtl/fir_mavg_stream.sv - streaming moving-average FIR built on a running-sum circular delay line
module fir_mavg_stream #(
    parameter int DW         = 16,
    parameter int LOG2_TAPS  = 2,
    parameter int ROUND      = 0,
    parameter int EMIT_EARLY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout,
    output logic                 primed
);

    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int SW   = DW + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0]    FULL = (LOG2_TAPS + 1)'(TAPS);
    localparam logic signed [SW-1:0]  BIAS = (ROUND != 0) ? SW'(TAPS / 2) : '0;

    logic signed [DW-1:0]  taps_q [TAPS];
    logic [LOG2_TAPS-1:0]  wr_ptr;
    logic [LOG2_TAPS:0]    fill_q;
    logic [LOG2_TAPS:0]    fill_next;
    logic signed [SW-1:0]  sum_q;
    logic signed [SW-1:0]  sum_next;
    logic signed [SW-1:0]  din_ext;
    logic signed [SW-1:0]  oldest_ext;
    logic signed [SW-1:0]  rounded;
    logic signed [SW-1:0]  shifted;

    // The sum width holds TAPS full-scale samples plus the rounding bias, so nothing wraps.
    always_comb begin
        din_ext    = {{LOG2_TAPS{din[DW-1]}}, din};
        oldest_ext = {{LOG2_TAPS{taps_q[wr_ptr][DW-1]}}, taps_q[wr_ptr]};
        sum_next   = sum_q + din_ext - oldest_ext;
        rounded    = sum_next + BIAS;
        shifted    = rounded >>> LOG2_TAPS;
        fill_next  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            wr_ptr    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            wr_ptr    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else if (in_valid) begin
            taps_q[wr_ptr] <= din;
            wr_ptr         <= wr_ptr + 1'b1;
            fill_q         <= fill_next;
            sum_q          <= sum_next;
            // dout tracks every sample; out_valid alone hides the warm-up when EMIT_EARLY=0.
            dout           <= shifted[DW-1:0];
            out_valid      <= (EMIT_EARLY != 0) || (fill_next == FULL);
            primed         <= (fill_next == FULL);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mavg_stream.sv
// tb/tb_fir_mavg_stream.sv - scoreboard bench running four filter configurations on one shared stream
module tb_fir_mavg_stream;

    localparam int N = 4;
    localparam int LG [N] = '{2, 2, 2, 3};
    localparam int RD [N] = '{0, 1, 0, 1};
    localparam int EE [N] = '{1, 1, 0, 0};

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic signed [15:0] din;
    logic               out_valid_w [N];
    logic signed [15:0] dout_w      [N];
    logic               primed_w    [N];

    int                 hist [$];
    logic signed [15:0] expq [N][$];
    logic signed [15:0] exp_dout   [N];
    logic               exp_primed [N];
    logic               done = 1'b0;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    fir_mavg_stream #(.DW(16), .LOG2_TAPS(2), .ROUND(0), .EMIT_EARLY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid_w[0]), .dout(dout_w[0]), .primed(primed_w[0]));
    fir_mavg_stream #(.DW(16), .LOG2_TAPS(2), .ROUND(1), .EMIT_EARLY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid_w[1]), .dout(dout_w[1]), .primed(primed_w[1]));
    fir_mavg_stream #(.DW(16), .LOG2_TAPS(2), .ROUND(0), .EMIT_EARLY(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid_w[2]), .dout(dout_w[2]), .primed(primed_w[2]));
    fir_mavg_stream #(.DW(16), .LOG2_TAPS(3), .ROUND(1), .EMIT_EARLY(0)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .din(din),
        .out_valid(out_valid_w[3]), .dout(dout_w[3]), .primed(primed_w[3]));

    // Average of the last TAPS accepted samples (zeros before that), floored after optional +TAPS/2.
    function automatic longint model_avg(int idx);
        longint t = longint'(1) << LG[idx];
        longint s = 0;
        longint q;
        for (int j = 0; j < t; j++)
            if (j < hist.size()) s += hist[hist.size() - 1 - j];
        if (RD[idx] != 0) s += t / 2;
        q = s / t;
        if (s < 0 && (s % t) != 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < N; i++) begin
            exp_dout[i]   = '0;
            exp_primed[i] = 1'b0;
            expq[i].delete();
        end
    endfunction

    task automatic step(input logic v, input int d, input logic c);
        longint a;
        in_valid = v;
        din      = d[15:0];
        clr      = c;
        @(posedge clk);
        #1;
        if (c) begin
            model_clear();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            for (int i = 0; i < N; i++) begin
                a = model_avg(i);
                exp_dout[i]   = a[15:0];
                exp_primed[i] = (hist.size() >= (1 << LG[i]));
                if (EE[i] != 0 || exp_primed[i]) expq[i].push_back(a[15:0]);
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    initial begin : monitor
        int cycles = 0;
        logic signed [15:0] e;
        while (!done && cycles < 50000) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    check("reset_dout", i, dout_w[i], 0);
                    check("reset_out_valid", i, longint'(out_valid_w[i]), 0);
                    check("reset_primed", i, longint'(primed_w[i]), 0);
                end else begin
                    check("dout_hold", i, dout_w[i], exp_dout[i]);
                    check("primed", i, longint'(primed_w[i]), longint'(exp_primed[i]));
                    if (out_valid_w[i]) begin
                        if (expq[i].size() == 0) begin
                            check("unexpected_out_valid", i, 1, 0);
                        end else begin
                            e = expq[i].pop_front();
                            check("dout", i, dout_w[i], e);
                        end
                    end else if (expq[i].size() != 0) begin
                        e = expq[i].pop_front();
                        check("missing_out_valid", i, 0, 1);
                    end
                end
            end
        end
        if (!done) check("timeout", 0, cycles, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        int d;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        model_clear();
        #23;
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) step(1'b1, 100, 1'b0);
        step(1'b0, 0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 32767, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, -32768, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, -1, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8, 1'b0);
            step(1'b0, 0, 1'b0);
            step(1'b0, 0, 1'b0);
        end
        step(1'b0, 0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, 40, 1'b0);
        step(1'b1, 400, 1'b1);
        step(1'b1, 400, 1'b0);
        step(1'b1, 400, 1'b0);
        step(1'b0, 0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 100, 1'b0);
        do_reset();
        step(1'b1, 100, 1'b0);
        step(1'b0, 0, 1'b0);

        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 7))
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0);
        end
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
        done = 1'b1;
    end

endmodule
